// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with a two-entry skid buffer so in_ready is registered.
// Optional stall counter output when PIPE_SKID_STATS_EN is defined.
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pipelined_out
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             main_ld, skid_ld, main_from_skid;
  logic             accept, pop;

  // Handshakes depend only on registered state, never combinationally on out_ready -> in_ready.
  assign in_ready      = (state_q != S_TWO);
  assign out_valid     = (state_q != S_EMPTY);
  assign pipelined_out = main_q;
  assign accept        = in_valid & in_ready;
  assign pop           = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          main_ld = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          state_d = S_TWO;
          skid_ld = 1'b1;
        end else if (accept && pop) begin
          main_ld = 1'b1;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          state_d        = S_ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // A squash discards everything held plus any same-cycle accept; data regs are left untouched.
    if (flush) begin
      state_d = S_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
    main_d = main_from_skid ? skid_q : in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (main_ld) main_q <= main_d;
      if (skid_ld) skid_q <= in;
    end
  end

`ifdef PIPE_SKID_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_q;

  // Counts cycles where downstream is holding off a valid word; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
